// File: rtl/pipeline_sequencer_if.sv
// pipeline_sequencer_if
//   Bundles the hit/request inputs and the latch-control outputs of the
//   pipeline sequencer.
//   master : pipeline/cache side. It drives the hits and requests, and it
//            consumes the enables, flushes, dcache requests, halt and
//            stall count.
//   slave  : the sequencer itself.
interface pipeline_sequencer_if #(
    parameter int CNT_W = 16
);
    // pipeline / cache -> sequencer
    logic             ihit;
    logic             dhit;
    logic             exmem_dREN;
    logic             exmem_dWEN;
    logic             exmem_halt;
    logic             redirect;
    logic             lu_hazard;

    // sequencer -> pipeline / cache
    logic             dmemREN;
    logic             dmemWEN;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             halt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output ihit, dhit, exmem_dREN, exmem_dWEN, exmem_halt, redirect, lu_hazard,
        input  dmemREN, dmemWEN, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halt, stall_cnt
    );

    modport slave (
        input  ihit, dhit, exmem_dREN, exmem_dWEN, exmem_halt, redirect, lu_hazard,
        output dmemREN, dmemWEN, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halt, stall_cnt
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer
//   Central stall/flush controller for a 5-stage pipeline. Each cycle it
//   decides whether the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB latches
//   load, hold or flush. It also issues the dcache access of the EX/MEM
//   instruction as a one-shot request.
//
//   Ports:
//     CLK  : clock
//     RST  : asynchronous active-high reset
//     bus  : pipeline_sequencer_if.slave
//            inputs  - ihit, dhit, exmem_dREN/dWEN, exmem_halt, redirect,
//                      lu_hazard
//            outputs - dmemREN/WEN, pc_en, *_en, *_flush, halt, stall_cnt
//
//   Priority when the pipeline advances, from highest to lowest:
//     redirect > exmem_halt > lu_hazard > normal.
module pipeline_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic               CLK,
    input  logic               RST,
    pipeline_sequencer_if.slave bus
);

    typedef enum logic {RUN, HALTED} seqState_e;

    seqState_e        stateQ, stateD;
    logic             fetchDone, memDone;
    logic             haltQ;
    logic [CNT_W-1:0] stallCnt;

    logic memOp, fOk, mOk, running, advance, goHalt;

    assign memOp   = bus.exmem_dREN | bus.exmem_dWEN;
    assign fOk     = bus.ihit | fetchDone;
    assign mOk     = ~memOp | bus.dhit | memDone;
    assign running = (stateQ == RUN);
    assign advance = running & fOk & mOk;
    // A halt only takes effect when it actually leaves EX/MEM. A redirect
    // in the same cycle wins.
    assign goHalt  = advance & bus.exmem_halt & ~bus.redirect;

    // Both dcache requests are gated with RST so that a request in flight
    // drops the moment reset is asserted. Otherwise it would reappear from
    // the still-set EX/MEM request bits.
    assign bus.dmemREN = ~RST & running & bus.exmem_dREN & ~memDone;
    assign bus.dmemWEN = ~RST & running & bus.exmem_dWEN & ~memDone;

    assign bus.halt      = haltQ;
    assign bus.stall_cnt = stallCnt;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) stateQ <= RUN;
        else     stateQ <= stateD;
    end

    // Next state and latch controls
    always_comb begin
        stateD          = stateQ;
        bus.pc_en       = 1'b0;
        bus.ifid_en     = 1'b0;
        bus.idex_en     = 1'b0;
        bus.exmem_en    = 1'b0;
        bus.memwb_en    = 1'b0;
        bus.ifid_flush  = 1'b0;
        bus.idex_flush  = 1'b0;
        bus.exmem_flush = 1'b0;

        case (stateQ)
            RUN: begin
                if (advance) begin
                    if (bus.redirect) begin
                        // Squash the three wrong-path slots. The branch itself
                        // still retires into MEM/WB.
                        bus.pc_en       = 1'b1;
                        bus.ifid_en     = 1'b1;
                        bus.idex_en     = 1'b1;
                        bus.exmem_en    = 1'b1;
                        bus.memwb_en    = 1'b1;
                        bus.ifid_flush  = 1'b1;
                        bus.idex_flush  = 1'b1;
                        bus.exmem_flush = 1'b1;
                    end else if (bus.exmem_halt) begin
                        // Only the halt itself moves on. Everything behind it
                        // freezes.
                        bus.memwb_en = 1'b1;
                        stateD       = HALTED;
                    end else if (bus.lu_hazard) begin
                        // Hold PC and IF/ID, and put a bubble into ID/EX.
                        bus.idex_en    = 1'b1;
                        bus.idex_flush = 1'b1;
                        bus.exmem_en   = 1'b1;
                        bus.memwb_en   = 1'b1;
                    end else begin
                        bus.pc_en    = 1'b1;
                        bus.ifid_en  = 1'b1;
                        bus.idex_en  = 1'b1;
                        bus.exmem_en = 1'b1;
                        bus.memwb_en = 1'b1;
                    end
                end
            end
            HALTED: stateD = HALTED;
            default: stateD = RUN;
        endcase
    end

    // One-shot flags. A hit that arrives while the other side is still
    // stalled is remembered. This keeps the dcache from seeing a repeated
    // request, such as a second store. Clearing on advance wins over setting.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetchDone <= 1'b0;
            memDone   <= 1'b0;
        end else if (advance) begin
            fetchDone <= 1'b0;
            memDone   <= 1'b0;
        end else if (running) begin
            if (bus.ihit) fetchDone <= 1'b1;
            if (bus.dhit) memDone   <= 1'b1;
        end
    end

    // Registered halt. It is visible the cycle after the halt retires.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)         haltQ <= 1'b0;
        else if (goHalt) haltQ <= 1'b1;
    end

    // Stall counter. It counts RUN cycles that do not advance, saturates at
    // all-ones, and is frozen once halted.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            stallCnt <= '0;
        else if (running && !advance && (stallCnt != {CNT_W{1'b1}}))
            stallCnt <= stallCnt + 1'b1;
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
module tb_pipeline_sequencer;

    localparam int CNT_W = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pipeline_sequencer_if #(.CNT_W(CNT_W)) bus ();

    pipeline_sequencer #(.CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packs the nine latch controls as {pc, ifid, idex, exmem, memwb,
    // ifid_fl, idex_fl, exmem_fl, halt}.
    function automatic logic [15:0] ctl();
        return {7'd0, bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.halt};
    endfunction

    task automatic drive(input logic ih, input logic dh, input logic rd, input logic wr,
                         input logic hl, input logic rdr, input logic lu);
        bus.ihit       = ih;
        bus.dhit       = dh;
        bus.exmem_dREN = rd;
        bus.exmem_dWEN = wr;
        bus.exmem_halt = hl;
        bus.redirect   = rdr;
        bus.lu_hazard  = lu;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);

        // Reset state
        #1;
        chk("rst_halt", {15'd0, bus.halt}, 16'd0);
        chk("rst_cnt", {12'd0, bus.stall_cnt}, 16'd0);
        chk("rst_dren", {15'd0, bus.dmemREN}, 16'd0);
        @(negedge CLK); @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("run_all_en", ctl(), 16'b1_1111_0000);
        chk("run_cnt", {12'd0, bus.stall_cnt}, 16'd0);

        // Store: dhit on cycle 2, ihit on cycle 4
        @(negedge CLK); drive(0, 0, 0, 1, 0, 0, 0); #1;
        chk("st_c1_wen", {15'd0, bus.dmemWEN}, 16'd1);
        chk("st_c1_ctl", ctl(), 16'd0);
        @(negedge CLK); drive(0, 1, 0, 1, 0, 0, 0); #1;
        chk("st_c2_wen", {15'd0, bus.dmemWEN}, 16'd1);
        chk("st_c2_ctl", ctl(), 16'd0);
        @(negedge CLK); drive(0, 0, 0, 1, 0, 0, 0); #1;
        chk("st_c3_wen", {15'd0, bus.dmemWEN}, 16'd0);
        chk("st_c3_ctl", ctl(), 16'd0);
        chk("st_c3_cnt", {12'd0, bus.stall_cnt}, 16'd2);
        @(negedge CLK); drive(1, 0, 0, 1, 0, 0, 0); #1;
        chk("st_c4_wen", {15'd0, bus.dmemWEN}, 16'd0);
        chk("st_c4_ctl", ctl(), 16'b1_1111_0000);
        chk("st_c4_cnt", {12'd0, bus.stall_cnt}, 16'd3);

        // Flags cleared by advance: a new load requests again and completes
        @(negedge CLK); drive(1, 1, 1, 0, 0, 0, 0); #1;
        chk("ld_ren", {15'd0, bus.dmemREN}, 16'd1);
        chk("ld_ctl", ctl(), 16'b1_1111_0000);
        chk("ld_cnt", {12'd0, bus.stall_cnt}, 16'd3);

        // Load-use bubble
        @(negedge CLK); drive(1, 0, 0, 0, 0, 0, 1); #1;
        chk("lu_ctl", ctl(), 16'b0_0111_0100);

        // Redirect beats load-use
        @(negedge CLK); drive(1, 0, 0, 0, 0, 1, 1); #1;
        chk("rdr_ctl", ctl(), 16'b1_1111_1110);

        // Halt retires, then everything stays frozen
        @(negedge CLK); drive(1, 0, 0, 0, 1, 0, 0); #1;
        chk("hlt_ctl", ctl(), 16'b0_0001_0000);
        @(negedge CLK); drive(1, 0, 1, 0, 0, 0, 0); #1;
        chk("hlt_next", ctl(), 16'b0_0000_0001);
        chk("hlt_ren", {15'd0, bus.dmemREN}, 16'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK); drive(1, 0, 0, 0, 0, 0, 0); #1;
            chk($sformatf("hlt_frz%0d", i), ctl(), 16'b0_0000_0001);
            chk($sformatf("hlt_cnt%0d", i), {12'd0, bus.stall_cnt}, 16'd3);
        end

        // Reset out of HALTED, then saturate the counter
        @(negedge CLK); RST = 1'b1; #1;
        chk("rst2_halt", {15'd0, bus.halt}, 16'd0);
        @(negedge CLK); RST = 1'b0; drive(0, 0, 1, 0, 0, 0, 0);
        repeat (10) @(posedge CLK);
        @(negedge CLK); #1;
        chk("sat_cnt10", {12'd0, bus.stall_cnt}, 16'd10);
        repeat (10) @(posedge CLK);
        @(negedge CLK); #1;
        chk("sat_cnt20", {12'd0, bus.stall_cnt}, 16'd15);
        chk("sat_ren", {15'd0, bus.dmemREN}, 16'd1);
        chk("sat_ctl", ctl(), 16'd0);

        // Asynchronous reset in mid-access
        #1 RST = 1'b1; #1;
        chk("arst_ren", {15'd0, bus.dmemREN}, 16'd0);
        chk("arst_cnt", {12'd0, bus.stall_cnt}, 16'd0);
        @(negedge CLK); RST = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
